seq_calc_ctrl: RTL



---
 rtl/seq_calc_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/seq_calc_ctrl.sv
// ============================================================================
// Module   : seq_calc_ctrl
// Brief    : Folds a handshaked operand sequence with add/max/min/xor and
//            strobes the result into the downstream result register.
//            Optional SEQ_CALC_SAT_EN: saturating add instead of wrapping add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_calc_ctrl #(
    parameter int WIDTH = 8,
    parameter int LEN_W = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic [WIDTH-1:0] res_data,
    output logic             res_en,
    output logic             busy,
    output logic             ovf
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_FIRST  = 2'd1;
    localparam logic [1:0] c_ACCUM  = 2'd2;
    localparam logic [1:0] c_FINISH = 2'd3;

    localparam logic [1:0] c_OP_ADD = 2'b00;
    localparam logic [1:0] c_OP_MAX = 2'b01;
    localparam logic [1:0] c_OP_MIN = 2'b10;

    logic [1:0]       r_state;
    logic [1:0]       w_next;
    logic [1:0]       r_op;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_res;
    logic             r_ovf;

    logic             w_ready;
    logic             w_xfer;
    logic [LEN_W-1:0] w_cnt_inc;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_add;
    logic [WIDTH-1:0] w_fold;
    logic [WIDTH-1:0] w_acc_nxt;

    assign w_ready   = (r_state == c_FIRST) || (r_state == c_ACCUM);
    assign w_xfer    = w_ready && in_valid;
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_sum     = {1'b0, r_acc} + {1'b0, in_data};

`ifdef SEQ_CALC_SAT_EN
    // Once clamped, any further add keeps the accumulator pinned at full scale.
    assign w_add = w_sum[WIDTH] ? {WIDTH{1'b1}} : w_sum[WIDTH-1:0];
`else
    assign w_add = w_sum[WIDTH-1:0];
`endif

    always_comb begin
        case (r_op)
            c_OP_ADD: w_fold = w_add;
            c_OP_MAX: w_fold = (in_data > r_acc) ? in_data : r_acc;
            c_OP_MIN: w_fold = (in_data < r_acc) ? in_data : r_acc;
            default:  w_fold = r_acc ^ in_data;
        endcase
    end

    always_comb begin
        w_acc_nxt = r_acc;
        case (r_state)
            c_IDLE:  if (start)  w_acc_nxt = '0;
            c_FIRST: if (w_xfer) w_acc_nxt = in_data;
            c_ACCUM: if (w_xfer) w_acc_nxt = w_fold;
            default: w_acc_nxt = r_acc;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) r_state <= c_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) w_next = (len == '0) ? c_FINISH : c_FIRST;
            end
            c_FIRST: begin
                if (w_xfer) w_next = (r_len == LEN_W'(1)) ? c_FINISH : c_ACCUM;
            end
            c_ACCUM: begin
                if (w_xfer && (w_cnt_inc == r_len)) w_next = c_FINISH;
            end
            default: w_next = c_IDLE;
        endcase
    end

    // Outputs decoded from the registered state only
    always_comb begin
        in_ready = w_ready;
        busy     = (r_state != c_IDLE);
        res_en   = (r_state == c_FINISH);
        res_data = r_res;
        ovf      = r_ovf;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= '0;
            r_len <= '0;
            r_cnt <= '0;
            r_acc <= '0;
            r_res <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_nxt;
            // Result is captured on entry so it is already valid while res_en is high.
            if (w_next == c_FINISH) r_res <= w_acc_nxt;
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_op  <= op;
                        r_len <= len;
                        r_cnt <= '0;
                        r_ovf <= 1'b0;
                    end
                end
                c_FIRST: begin
                    if (w_xfer) r_cnt <= LEN_W'(1);
                end
                c_ACCUM: begin
                    if (w_xfer) begin
                        r_cnt <= w_cnt_inc;
                        if ((r_op == c_OP_ADD) && w_sum[WIDTH]) r_ovf <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire
